// File: rtl/truth_table_bist.sv
// Exhaustive truth-table checker for a small combinational function.
// Steps every input vector, samples f_in at the end of each hold window.
module truth_table_bist #(
  parameter int N_IN = 4,
  parameter logic [2**N_IN-1:0] EXPECTED = 16'hA5C3,
  parameter int HOLD = 20
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            f_in,
  output logic [N_IN-1:0] vec_out,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic [N_IN-1:0] first_fail,
  output logic            fail_valid
);

  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [N_IN-1:0] LAST = N_IN'(2**N_IN - 1);
  localparam logic [HW-1:0] HLAST = HW'(HOLD - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t          state, state_n;
  logic [N_IN-1:0] index, index_n;
  logic [HW-1:0]   hold_cnt, hold_n;
  logic            busy_n, done_n, pass_n;
  logic [N_IN:0]   err_n;
  logic [N_IN-1:0] ff_n;
  logic            fv_n;
  logic            sample, mismatch;

  assign vec_out  = index;
  assign sample   = (hold_cnt == HLAST);
  assign mismatch = (f_in != EXPECTED[index]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      index      <= '0;
      hold_cnt   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
      first_fail <= '0;
      fail_valid <= 1'b0;
    end else begin
      state      <= state_n;
      index      <= index_n;
      hold_cnt   <= hold_n;
      busy       <= busy_n;
      done       <= done_n;
      pass       <= pass_n;
      err_count  <= err_n;
      first_fail <= ff_n;
      fail_valid <= fv_n;
    end
  end

  always_comb begin
    state_n = state;
    index_n = index;
    hold_n  = hold_cnt;
    busy_n  = busy;
    done_n  = done;
    pass_n  = pass;
    err_n   = err_count;
    ff_n    = first_fail;
    fv_n    = fail_valid;
    unique case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_n = S_RUN;
          index_n = '0;
          hold_n  = '0;
          busy_n  = 1'b1;
          done_n  = 1'b0;
          pass_n  = 1'b0;
          err_n   = '0;
          ff_n    = '0;
          fv_n    = 1'b0;
        end
      end
      S_RUN: begin
        hold_n = hold_cnt + HW'(1);
        if (sample) begin
          hold_n = '0;
          if (mismatch) begin
            err_n = err_count + (N_IN + 1)'(1);
            if (!fail_valid) begin
              ff_n = index;
              fv_n = 1'b1;
            end
          end
          if (index == LAST) begin
            state_n = S_DONE;
            index_n = '0;
            busy_n  = 1'b0;
            done_n  = 1'b1;
            pass_n  = (err_n == '0);
          end else begin
            index_n = index + N_IN'(1);
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_truth_table_bist.sv
// Bench for truth_table_bist: HOLD=20 and HOLD=1 instances,
// behavioural DUT models on f_in, scoreboard of sweep results.
module tb_truth_table_bist;

  localparam logic [15:0] EXP = 16'hA5C3;

  typedef struct {
    int err;
    int ff;
    bit fv;
    bit pass;
    int lat;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst20 = 1'b0, rst1 = 1'b0;
  logic       start20 = 1'b0, start1 = 1'b0;
  logic       f20, f1;
  int         mode20 = 0, mode1 = 0;
  logic [3:0] vec20, vec1;
  logic       busy20, busy1, done20, done1, pass20, pass1;
  logic [4:0] err20, err1;
  logic [3:0] ff20, ff1;
  logic       fv20, fv1;

  logic       sel = 1'b0;
  wire  [3:0] vec_s  = sel ? vec1 : vec20;
  wire        busy_s = sel ? busy1 : busy20;
  wire        done_s = sel ? done1 : done20;
  wire        pass_s = sel ? pass1 : pass20;
  wire  [4:0] err_s  = sel ? err1 : err20;
  wire  [3:0] ff_s   = sel ? ff1 : ff20;
  wire        fv_s   = sel ? fv1 : fv20;

  // 0 golden, 1 stuck-0, 2 stuck-1, 3 golden with vector 9 inverted
  function automatic logic fmodel(input int mode, input logic [3:0] v);
    logic [15:0] t;
    t = EXP;
    case (mode)
      1: return 1'b0;
      2: return 1'b1;
      3: return t[v] ^ (v == 4'd9);
      default: return t[v];
    endcase
  endfunction

  assign f20 = fmodel(mode20, vec20);
  assign f1  = fmodel(mode1, vec1);

  truth_table_bist #(.N_IN(4), .EXPECTED(16'hA5C3), .HOLD(20)) u_dut (
    .clk(clk), .rst_n(rst20), .start(start20), .f_in(f20),
    .vec_out(vec20), .busy(busy20), .done(done20), .pass(pass20),
    .err_count(err20), .first_fail(ff20), .fail_valid(fv20)
  );

  truth_table_bist #(.N_IN(4), .EXPECTED(16'hA5C3), .HOLD(1)) u_dut1 (
    .clk(clk), .rst_n(rst1), .start(start1), .f_in(f1),
    .vec_out(vec1), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .first_fail(ff1), .fail_valid(fv1)
  );

  task automatic drive_start(input logic x);
    if (sel) start1 = x;
    else start20 = x;
  endtask

  task automatic drive_rst(input logic x);
    if (sel) rst1 = x;
    else rst20 = x;
  endtask

  function automatic exp_t model_sweep(input int mode, input int hold);
    exp_t e;
    logic [15:0] t;
    t = EXP;
    e.err = 0;
    e.ff = 0;
    e.fv = 0;
    for (int v = 0; v < 16; v++) begin
      if (fmodel(mode, 4'(v)) != t[v]) begin
        if (!e.fv) begin
          e.ff = v;
          e.fv = 1;
        end
        e.err++;
      end
    end
    e.pass = (e.err == 0);
    e.lat = 16 * hold;
    return e;
  endfunction

  task automatic check_zero(input string name);
    logic [16:0] got;
    got = {vec_s, busy_s, done_s, pass_s, err_s, ff_s, fv_s};
    checks++;
    if (got !== '0) begin
      failures++;
      $display("FAIL %s outputs=%h required=0", name, got);
    end
  endtask

  task automatic sweep(input bit h1, input int mode, input int pulse_at,
                       input int rst_at, input bit chk_clear);
    int hold;
    int total;
    bit got;
    int lat;
    exp_t e;
    hold = h1 ? 1 : 20;
    total = 16 * hold;
    sel = h1;
    if (h1) mode1 = mode;
    else mode20 = mode;
    @(negedge clk);
    drive_start(1'b1);
    sb.push_back(model_sweep(mode, hold));
    @(posedge clk);
    #1;
    drive_start(1'b0);
    if (chk_clear) begin
      checks++;
      if ({busy_s, done_s, err_s, fv_s} !== 8'b1000_0000) begin
        failures++;
        $display("FAIL clear_at_start busy=%b done=%b err=%0d fv=%b required busy=1 rest=0",
                 busy_s, done_s, err_s, fv_s);
      end
    end
    got = 0;
    lat = 0;
    for (int k = 1; k <= total + 50; k++) begin
      @(posedge clk);
      #1;
      drive_start(k == pulse_at);
      if (k == rst_at) begin
        drive_rst(1'b0);
        drive_start(1'b0);
        #1;
        check_zero("async_reset_abort");
        void'(sb.pop_front());
        @(negedge clk);
        drive_rst(1'b1);
        return;
      end
      if (done_s) begin
        got = 1;
        lat = k;
        break;
      end
      if (k % hold == 0) begin
        checks++;
        if (vec_s !== 4'(k / hold) || busy_s !== 1'b1) begin
          failures++;
          $display("FAIL vec_step k=%0d vec=%0d busy=%b required vec=%0d busy=1",
                   k, vec_s, busy_s, k / hold);
        end
      end
    end
    drive_start(1'b0);
    e = sb.pop_front();
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL done_timeout done never rose required latency=%0d", e.lat);
      return;
    end
    if (lat !== e.lat) begin
      failures++;
      $display("FAIL latency got=%0d required=%0d", lat, e.lat);
    end
    checks++;
    if (err_s !== 5'(e.err)) begin
      failures++;
      $display("FAIL err_count got=%0d required=%0d", err_s, e.err);
    end
    checks++;
    if (fv_s !== e.fv || (e.fv && ff_s !== 4'(e.ff))) begin
      failures++;
      $display("FAIL first_fail got=%0d/%b required=%0d/%b", ff_s, fv_s, e.ff, e.fv);
    end
    checks++;
    if (pass_s !== e.pass) begin
      failures++;
      $display("FAIL pass got=%b required=%b", pass_s, e.pass);
    end
    checks++;
    if (busy_s !== 1'b0 || vec_s !== 4'd0) begin
      failures++;
      $display("FAIL end_state busy=%b vec=%0d required 0/0", busy_s, vec_s);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (done_s !== 1'b1 || err_s !== 5'(e.err)) begin
      failures++;
      $display("FAIL done_hold done=%b err=%0d required 1/%0d", done_s, err_s, e.err);
    end
  endtask

  task automatic test_reset;
    rst20 = 1'b0;
    rst1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    sel = 1'b0;
    check_zero("reset_hold20");
    sel = 1'b1;
    check_zero("reset_hold1");
    @(negedge clk);
    rst20 = 1'b1;
    rst1 = 1'b1;
  endtask

  task automatic test_golden;
    sweep(1'b0, 0, 0, 0, 1'b0);
  endtask

  task automatic test_stuck;
    sweep(1'b0, 1, 0, 0, 1'b0);
    sweep(1'b0, 2, 0, 0, 1'b0);
  endtask

  task automatic test_hold1_vec9;
    sweep(1'b1, 3, 0, 0, 1'b0);
    sweep(1'b1, 0, 0, 0, 1'b1);
  endtask

  task automatic test_start_ignored_and_abort;
    sweep(1'b0, 0, 100, 0, 1'b0);
    sweep(1'b0, 0, 0, 150, 1'b0);
    sweep(1'b0, 0, 0, 0, 1'b0);
  endtask

  task automatic test_restart_from_done;
    sweep(1'b0, 1, 0, 0, 1'b0);
    sweep(1'b0, 0, 0, 0, 1'b1);
  endtask

  initial begin
    test_reset();
    test_golden();
    test_stuck();
    test_hold1_vec9();
    test_start_ignored_and_abort();
    test_restart_from_done();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/truth_table_bist.md
Name: truth_table_bist

Overview:
- Synthesizable checker for small combinational lab functions of N_IN inputs (default 4: A,B,C,D).
- Sweeps every input combination onto the DUT inputs in ascending binary order and holds each for a fixed number of clocks.
- Samples the DUT output at the end of each hold window, compares it to an expected truth table, and reports error count, first failing vector and pass/fail.
- Sits beside the DUT on the board and replaces a hand-written exhaustive stimulus bench.

Parameters:
- N_IN, 4, number of DUT inputs; sweep length is 2**N_IN vectors.
- EXPECTED, 16'hA5C3, expected truth table; bit i is the required f for input vector i. Width is 2**N_IN.
- HOLD, 20, clocks each vector is held; legal range is 1 and above.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle request to begin a sweep.
- f_in  input  1  DUT output under test.
- vec_out  output  N_IN  vector driven to the DUT; MSB = A, LSB = D.
- busy  output  1  high while a sweep is running.
- done  output  1  high after sweep completion, held until the next accepted start or reset.
- pass  output  1  valid when done=1; 1 means zero mismatches.
- err_count  output  N_IN+1  number of mismatching vectors; range 0..2**N_IN.
- first_fail  output  N_IN  index of the lowest-numbered mismatching vector.
- fail_valid  output  1  first_fail holds a valid value.

Behaviour:
- Clock and reset: single clock, clk. rst_n is asynchronous and active-low.
- Reset values: state=IDLE, vec_out=0, busy=0, done=0, pass=0, err_count=0, first_fail=0, fail_valid=0, internal hold counter=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at a rising edge moves to RUN.
  - At that edge, index=0 and hold_cnt=0; busy goes to 1.
  - err_count, first_fail, fail_valid, done and pass are all cleared at the same edge.
- RUN:
  - vec_out = index, registered. hold_cnt increments every clock.
  - Sample edge: the edge where hold_cnt==HOLD-1. At that edge f_in is compared with EXPECTED[index].
  - On mismatch: err_count increments. If fail_valid=0, first_fail=index and fail_valid=1 at the same edge.
  - If index < 2**N_IN-1 at the sample edge: index increments and hold_cnt returns to 0.
  - If index == 2**N_IN-1 at the sample edge: move to DONE. busy=0, done=1, vec_out=0.
  - pass is set to 1 exactly when err_count (including this final compare) is 0.
- DONE:
  - All results are held.
  - start=1 behaves as in IDLE: full clear and restart.
- Latency: done rises 2**N_IN*HOLD clocks after the edge that accepted start (320 clocks at default parameters).
- HOLD=1: every clock is a sample edge. The DUT must settle within one cycle of vec_out changing.
- start while busy=1 is ignored; the sweep continues undisturbed.
- start held high continuously restarts only from IDLE/DONE. A long pulse therefore re-runs the sweep immediately after done. Callers pulse start.
- err_count saturation is not required; its width covers the maximum of 2**N_IN.
- rst_n low mid-sweep aborts immediately (asynchronously) to the reset values. There is no partial result.
- f_in is used only at sample edges. Glitches between sample edges are ignored.

Test Plan:
- Golden DUT model (f = EXPECTED[vec]), HOLD=20: pulse start -> vec_out steps 0..15 every 20 clocks; done=1 at clock 320; pass=1, err_count=0, fail_valid=0.
- f_in stuck at 0 -> err_count=8 (popcount of 16'hA5C3), first_fail=0, fail_valid=1, pass=0.
- f_in stuck at 1 -> err_count=8, first_fail=2, pass=0.
- Golden model with vector 9 inverted, HOLD=1 -> err_count=1, first_fail=9, done at clock 16, pass=0.
- start pulsed at clock 100 of a run -> ignored; done still at clock 320. Then assert rst_n=0 at clock 150 of a second run -> all outputs 0 immediately, state IDLE. A new start then completes normally.
- Restart from DONE after a failing sweep, using the golden model -> err_count, fail_valid and done cleared at the start edge; final pass=1.
